// File: rtl/enc_sched_pkg.sv
// enc_sched_pkg: shared states and constants for the TX encoder scheduler.
package enc_sched_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DRAIN, GAP, DONE} state_t;
  localparam logic SRC_HDR = 1'b0;
  localparam logic SRC_PAY = 1'b1;
  localparam int NIB_BITS = 4;
  localparam int CW_BITS = 8;
endpackage

// File: rtl/enc_sched_arb.sv
// enc_sched_arb: 2-way header/payload arbiter; round-robin when ENC_SCHED_RR_EN is defined,
// fixed header priority otherwise.
module enc_sched_arb
  import enc_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] reqs,
  input  logic       enable,
  input  logic       frame_done,
  output logic       grant
);
`ifdef ENC_SCHED_RR_EN
  logic last_srv, cur;
  assign grant = enable & (&reqs ? ~last_srv : reqs[SRC_PAY]);
  // The pointer only advances on completed frames; a timed-out frame leaves it alone.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      last_srv <= SRC_PAY;
      cur <= SRC_HDR;
    end else begin
      if (enable && |reqs) cur <= grant;
      if (frame_done) last_srv <= cur;
    end
`else
  logic unused;
  assign unused = ^{clk, reset, frame_done};
  assign grant = enable & reqs[SRC_PAY] & ~reqs[SRC_HDR];
`endif
endmodule

// File: rtl/enc_tx_scheduler.sv
// enc_tx_scheduler: shares the (8,4) encoder between header and payload nibble sources.
// Define ENC_SCHED_RR_EN for round-robin arbitration instead of fixed header priority.
module enc_tx_scheduler
  import enc_sched_pkg::*;
#(
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 32,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hdr_req,
  input  logic                pay_req,
  input  logic [NIB_BITS-1:0] hdr_nibble,
  input  logic [NIB_BITS-1:0] pay_nibble,
  input  logic                hdr_last,
  input  logic                pay_last,
  output logic                hdr_ack,
  output logic                pay_ack,
  output logic                enc_bit,
  output logic                enc_bit_valid,
  input  logic                enc_out,
  input  logic                enc_out_valid,
  output logic                cw_bit,
  output logic                cw_valid,
  output logic                cw_owner,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_owner,
  output logic [CNT_W-1:0]    cw_count,
  output logic                err
);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int GP_W = $clog2(GAP_CYC + 2);
  state_t state, state_nx;
  logic owner, is_last, grant, src, take, cw_end, timeout;
  logic [NIB_BITS-1:0] nib;
  logic [1:0] sh_cnt;
  logic [2:0] bit_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [GP_W-1:0] gap_cnt;
  state_t nxt_frame;
  enc_sched_arb u_arb (
    .clk(clk),
    .reset(reset),
    .reqs({pay_req, hdr_req}),
    .enable(state == IDLE),
    .frame_done(frame_done),
    .grant(grant)
  );
  assign src = state == IDLE ? grant : owner;
  // Acks are gated by reset so an aborted frame never leaks a handshake.
  assign take = ~reset & (state == IDLE | state == FETCH) & (src ? pay_req : hdr_req);
  assign hdr_ack = take & ~src;
  assign pay_ack = take & src;
  assign enc_bit_valid = state == SHIFT;
  assign enc_bit = enc_bit_valid & nib[2'd3 - sh_cnt];
  assign cw_valid = state == DRAIN & enc_out_valid;
  assign cw_bit = cw_valid & enc_out;
  assign cw_owner = owner;
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  assign frame_owner = frame_done & owner;
  assign cw_end = cw_valid & (bit_cnt == 3'(CW_BITS - 1));
  assign timeout = state == DRAIN & ~cw_end & (to_cnt == TO_W'(TIMEOUT - 1));
  assign nxt_frame = is_last ? DONE : FETCH;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, FETCH: state_nx = take ? SHIFT : state;
      SHIFT: state_nx = sh_cnt == 2'd3 ? DRAIN : SHIFT;
      DRAIN: state_nx = cw_end ? (GAP_CYC == 0 ? nxt_frame : GAP) : timeout ? IDLE : DRAIN;
      GAP: state_nx = gap_cnt == GP_W'(GAP_CYC - 1) ? nxt_frame : GAP;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      owner <= SRC_HDR;
      is_last <= 1'b0;
      nib <= '0;
      sh_cnt <= '0;
      bit_cnt <= '0;
      to_cnt <= '0;
      gap_cnt <= '0;
      cw_count <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      if (take) begin
        owner <= src;
        nib <= src ? pay_nibble : hdr_nibble;
        is_last <= src ? pay_last : hdr_last;
      end
      sh_cnt <= state == SHIFT ? sh_cnt + 2'd1 : '0;
      bit_cnt <= state == DRAIN ? bit_cnt + 3'(cw_valid) : '0;
      to_cnt <= state == DRAIN ? to_cnt + TO_W'(1) : '0;
      gap_cnt <= state == GAP ? gap_cnt + GP_W'(1) : '0;
      if (take && state == IDLE) cw_count <= '0;
      else if (cw_end && ~&cw_count) cw_count <= cw_count + CNT_W'(1);
      if (timeout) err <= 1'b1;
    end
endmodule

// File: doc/enc_tx_scheduler.md
# enc_tx_scheduler

- Shares the transmit (8,4) block encoder between two nibble sources: the header/SIGNAL source and the payload source.
- Sits in the TX chain between the frame builders and the serial encoder.
- Grants one source per frame and feeds the encoder 4 data bits MSB-first per codeword.
- Counts the 8 returned code bits per codeword before issuing the next nibble, then reports frame completion or timeout.

## Interface
Parameters:
- GAP_CYC, 2 — idle cycles inserted after each returned codeword (0 allowed).
- TIMEOUT, 32 — max cycles in DRAIN waiting for 8 code bits.
- CNT_W, 8 — width of codeword counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- hdr_req / pay_req  in  1  source has a nibble ready.
- hdr_nibble / pay_nibble  in  4  data nibble.
- hdr_last / pay_last  in  1  nibble is the final one of the frame.
- hdr_ack / pay_ack  out  1  one-cycle pulse: nibble accepted this cycle.
- enc_bit  out  1  serial data bit to encoder.
- enc_bit_valid  out  1  enc_bit is a data bit.
- enc_out  in  1  encoder code bit.
- enc_out_valid  in  1  encoder code bit valid.
- cw_bit / cw_valid  out  1  code bit passthrough, gated to DRAIN.
- cw_owner  out  1  0 = header, 1 = payload.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_owner  out  1  owner of the frame just done.
- cw_count  out  CNT_W  codewords completed in the current/last frame.
- err  out  1  sticky timeout flag; cleared only by reset.

## Operation
FSM states: IDLE, FETCH, SHIFT, DRAIN, GAP, DONE.

- **IDLE:** if any req, the arbiter picks an owner, pulses its ack, latches nibble/last, clears cw_count, then goes to SHIFT. With no req, stays in IDLE.
- **FETCH:** waits, with no timeout, for the owner's req. On req, pulses ack, latches nibble/last, goes to SHIFT. The other source's req is ignored: the frame is locked to its owner.
- **SHIFT:** 4 cycles, enc_bit_valid=1, enc_bit = nibble[3], [2], [1], [0] in that order. Then goes to DRAIN, clearing the bit counter and the timeout counter.
- **DRAIN:**
  - Each enc_out_valid cycle increments the bit counter and drives cw_valid=1, cw_bit=enc_out.
  - On the 8th bit: cw_count increments (saturating at all-ones), then goes to GAP, or directly to DONE/FETCH when GAP_CYC=0.
  - If the timeout counter reaches TIMEOUT first: sets err, goes to IDLE, no frame_done, cw_count keeps its value.
- **GAP:** GAP_CYC cycles with no outputs active. Then goes to DONE if the latched last=1, else to FETCH.
- **DONE:** frame_done=1 and frame_owner=owner for one cycle, then goes to IDLE.

Boundary conditions:
- enc_out_valid outside DRAIN is ignored; cw_valid stays 0.
- A 9th valid bit cannot occur inside DRAIN, since the state exits on the 8th.
- Simultaneous hdr_req and pay_req in IDLE: resolved by the arbitration policy (see Configuration).
- A source deasserting req mid-frame stalls the scheduler in FETCH indefinitely.

## Timing
Reset values: every output is 0; state = IDLE; last-served = payload.

Cycle-level sequence:
- Cycle N: ack.
- Cycles N+1..N+4: enc_bit_valid.
- DRAIN is entered at N+5.
- Next ack, at the earliest: 1 cycle after the 8th code bit + GAP_CYC (FETCH with req already high).
- frame_done: 1 cycle after GAP for the last nibble.

Other timing rules:
- The timeout counter counts DRAIN cycles starting at 0 on entry; timeout fires on the cycle the count equals TIMEOUT-1 without the 8th bit.
- Asserting reset mid-frame aborts immediately and asynchronously. No ack, frame_done or err results; the encoder is expected to be reset by the same signal.

## Configuration
ENC_SCHED_RR_EN:
- Defined: round-robin arbitration. On simultaneous requests in IDLE, the source not served in the previous frame wins; the first contest after reset goes to header.
- Undefined: fixed priority, header always wins. The last-served register is not implemented.

## Structure
- Package enc_sched_pkg:
  - state enum.
  - SRC_HDR=1'b0, SRC_PAY=1'b1.
  - NIB_BITS=4, CW_BITS=8.
- Sub-module enc_sched_arb: 2-way arbiter.
  - Inputs: reqs, enable (IDLE only), frame_done.
  - Output: grant.
  - Holds the RR pointer under ENC_SCHED_RR_EN.

## Test plan
- Header frame of 2 nibbles 4'hA, 4'h3 (last on the second); encoder model returns 8 bits 2 cycles after the 4th data bit. Required:
  - enc_bit sequence 1,0,1,0 then 0,0,1,1.
  - frame_done with frame_owner=0.
  - cw_count=2.
- hdr_req and pay_req both high in IDLE. Required:
  - Without the macro: header is granted on two consecutive frames.
  - With ENC_SCHED_RR_EN: header is granted first, then payload.
- Payload req high throughout a header frame → pay_ack stays 0 until after frame_done, then is granted.
- Encoder model returns only 5 bits, TIMEOUT=32. Required:
  - err=1 at DRAIN cycle 32.
  - State returns to IDLE, no frame_done.
  - err stays high afterwards.
- GAP_CYC=0, payload frame of 3 nibbles with req held high → consecutive acks spaced exactly 4+8+encoder-latency+1 cycles apart; cw_count=3.
- Reset asserted during SHIFT → all outputs 0 immediately; after release, a new header request is acked and serialized cleanly.
